// File: rtl/operand_pkg.sv
// Shared operand-fetch types: source-operand kind, access-size encoding and a
// zero-extension helper used when trimming operands to the instruction width.
package operand_pkg;

  typedef enum logic [1:0] {
    REGISTER = 2'd0,
    MEMORY   = 2'd1,
    IMM      = 2'd2
  } operand_t;

  typedef enum logic [1:0] {
    SIZE_8  = 2'd0,
    SIZE_16 = 2'd1,
    SIZE_32 = 2'd2,
    SIZE_64 = 2'd3
  } size_e;

  localparam int unsigned ZEXT_W = 64;

  // Keeps only the low 8/16/32/64 bits of val; everything above is cleared.
  function automatic logic [ZEXT_W-1:0] zext_by_size(input logic [ZEXT_W-1:0] val,
                                                     input size_e size);
    logic [ZEXT_W-1:0] res;
    res = '0;
    case (size)
      SIZE_8:  res[7:0]  = val[7:0];
      SIZE_16: res[15:0] = val[15:0];
      SIZE_32: res[31:0] = val[31:0];
      default: res       = val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Per-register busy bits for in-flight destinations. Set and clear may target
// the same register in one cycle; the set wins so the new producer stays tracked.
module of_scoreboard #(
  parameter int NREGS  = 16,
  parameter int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [RIDX_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [RIDX_W-1:0] clr_idx,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
    assign busy_d[gi] = (set_en && (set_idx == RIDX_W'(gi))) ||
                        (busy_q[gi] && !(clr_en && (clr_idx == RIDX_W'(gi))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads register operands, blocks on scoreboard hazards and holds
// one result entry. Optional macro OPERAND_FETCH_BYPASS_EN forwards writeback data.
module operand_fetch_stage
  import operand_pkg::*;
#(
  parameter  int XLEN   = 64,
  parameter  int NREGS  = 16,
  parameter  int OP_W   = 8,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_nop,
  input  logic [1:0]        in_srcty,
  input  logic [XLEN-1:0]   in_srcval,
  input  logic [RIDX_W-1:0] in_dst,
  input  logic [1:0]        in_size,
  output logic [RIDX_W-1:0] rf_raddr_a,
  input  logic [XLEN-1:0]   rf_rdata_a,
  output logic [RIDX_W-1:0] rf_raddr_b,
  input  logic [XLEN-1:0]   rf_rdata_b,
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_reg,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic              out_nop,
  output logic              out_mem,
  output logic [XLEN-1:0]   out_oper1,
  output logic [XLEN-1:0]   out_oper2,
  output logic [RIDX_W-1:0] out_dst,
  output logic [1:0]        out_size
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              nop_q, nop_d;
  logic              mem_q, mem_d;
  logic [XLEN-1:0]   oper1_q, oper1_d;
  logic [XLEN-1:0]   oper2_q, oper2_d;
  logic [RIDX_W-1:0] dst_q, dst_d;
  logic [1:0]        size_q, size_d;

  logic [RIDX_W-1:0] src_idx;
  logic [NREGS-1:0]  busy;
  operand_t          srcty;
  logic              dst_pend, src_pend, stall, accept;
  logic [XLEN-1:0]   data_a, data_b;

  function automatic logic [XLEN-1:0] zext_x(input logic [XLEN-1:0] v, input logic [1:0] s);
    return XLEN'(zext_by_size(ZEXT_W'(v), size_e'(s)));
  endfunction

  assign src_idx    = in_srcval[RIDX_W-1:0];
  assign rf_raddr_a = in_dst;
  assign rf_raddr_b = src_idx;
  assign srcty      = operand_t'(in_srcty);

`ifdef OPERAND_FETCH_BYPASS_EN
  logic byp_a, byp_b;
  // A register retiring this cycle is already resolved; take its value off the writeback bus.
  assign byp_a    = wb_valid && (wb_reg == in_dst);
  assign byp_b    = wb_valid && (wb_reg == src_idx);
  assign dst_pend = busy[in_dst]  && !byp_a;
  assign src_pend = busy[src_idx] && !byp_b;
  assign data_a   = byp_a ? wb_data : rf_rdata_a;
  assign data_b   = byp_b ? wb_data : rf_rdata_b;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign dst_pend = busy[in_dst];
  assign src_pend = busy[src_idx];
  assign data_a   = rf_rdata_a;
  assign data_b   = rf_rdata_b;
`endif

  assign stall    = in_valid && !in_nop && (dst_pend || ((srcty == REGISTER) && src_pend));
  assign in_ready = !reset && ((state_q == EMPTY) || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  of_scoreboard #(
    .NREGS  (NREGS),
    .RIDX_W (RIDX_W)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && !in_nop),
    .set_idx (in_dst),
    .clr_en  (wb_valid),
    .clr_idx (wb_reg),
    .busy    (busy)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Payload only moves on accept, which keeps outputs frozen under backpressure.
  always_comb begin
    op_d    = op_q;
    nop_d   = nop_q;
    mem_d   = mem_q;
    oper1_d = oper1_q;
    oper2_d = oper2_q;
    dst_d   = dst_q;
    size_d  = size_q;
    if (accept) begin
      op_d    = in_op;
      nop_d   = in_nop;
      dst_d   = in_dst;
      size_d  = in_size;
      mem_d   = 1'b0;
      oper1_d = '0;
      oper2_d = '0;
      if (!in_nop) begin
        oper1_d = zext_x(data_a, in_size);
        case (srcty)
          REGISTER: oper2_d = zext_x(data_b, in_size);
          MEMORY: begin
            oper2_d = in_srcval;
            mem_d   = 1'b1;
          end
          default:  oper2_d = zext_x(in_srcval, in_size);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      op_q    <= '0;
      nop_q   <= 1'b0;
      mem_q   <= 1'b0;
      oper1_q <= '0;
      oper2_q <= '0;
      dst_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      nop_q   <= nop_d;
      mem_q   <= mem_d;
      oper1_q <= oper1_d;
      oper2_q <= oper2_d;
      dst_q   <= dst_d;
      size_q  <= size_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_op    = op_q;
  assign out_nop   = nop_q;
  assign out_mem   = mem_q;
  assign out_oper1 = oper1_q;
  assign out_oper2 = oper2_q;
  assign out_dst   = dst_q;
  assign out_size  = size_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed hazard/backpressure/reset scenarios then
// random traffic, all checked against a cycle-level reference model of the stage.
module tb_operand_fetch_stage;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_nop;
  logic [7:0]  in_op;
  logic [1:0]  in_srcty, in_size;
  logic [63:0] in_srcval;
  logic [3:0]  in_dst;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [63:0] rf_rdata_a, rf_rdata_b;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [63:0] wb_data;
  logic        out_valid, out_ready, out_nop, out_mem;
  logic [7:0]  out_op;
  logic [63:0] out_oper1, out_oper2;
  logic [3:0]  out_dst;
  logic [1:0]  out_size;

  logic [63:0] rf_m [16];
  assign rf_rdata_a = rf_m[rf_raddr_a];
  assign rf_rdata_b = rf_m[rf_raddr_b];

  operand_fetch_stage #(.XLEN(64), .NREGS(16), .OP_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_nop(in_nop),
    .in_srcty(in_srcty), .in_srcval(in_srcval), .in_dst(in_dst), .in_size(in_size),
    .rf_raddr_a(rf_raddr_a), .rf_rdata_a(rf_rdata_a),
    .rf_raddr_b(rf_raddr_b), .rf_rdata_b(rf_rdata_b),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_nop(out_nop),
    .out_mem(out_mem), .out_oper1(out_oper1), .out_oper2(out_oper2),
    .out_dst(out_dst), .out_size(out_size)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txns   = 0;
  bit last_rdy;

  // Reference model state: the held entry, pending-register set.
  bit          full_m;
  bit          pend_m [16];
  logic [7:0]  m_op;
  bit          m_nop, m_mem;
  logic [63:0] m_o1, m_o2;
  logic [3:0]  m_dst;
  logic [1:0]  m_size;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] zext_m(input logic [63:0] v, input logic [1:0] s);
    int bits;
    bits = 8 << s;
    if (bits >= 64) return v;
    return v % (64'd1 << bits);
  endfunction

  function automatic bit retiring(input logic [3:0] r);
    return BYP && wb_valid && (wb_reg == r);
  endfunction

  function automatic bit pending(input logic [3:0] r);
    return pend_m[r] && !retiring(r);
  endfunction

  function automatic logic [63:0] reg_now(input logic [3:0] r);
    return retiring(r) ? wb_data : rf_m[r];
  endfunction

  // Checks the current cycle against the model, then advances the model past the edge.
  task automatic cycle();
    bit exp_rdy, stall_m, acc;
    logic [3:0] src;
    #1;
    check_val("out_valid", out_valid, full_m);
    if (full_m) begin
      check_val("out_op", out_op, m_op);
      check_val("out_nop", out_nop, m_nop);
      check_val("out_mem", out_mem, m_mem);
      check_val("out_oper1", out_oper1, m_o1);
      check_val("out_oper2", out_oper2, m_o2);
      check_val("out_dst", out_dst, m_dst);
      check_val("out_size", out_size, m_size);
    end
    src = in_srcval[3:0];
    check_val("rf_raddr_a", rf_raddr_a, in_dst);
    check_val("rf_raddr_b", rf_raddr_b, src);
    stall_m = in_valid && !in_nop && (pending(in_dst) || (in_srcty == 2'd0 && pending(src)));
    exp_rdy = !reset && (!full_m || out_ready) && !stall_m;
    check_val("in_ready", in_ready, exp_rdy);
    last_rdy = in_ready;
    acc = in_valid && exp_rdy;
    @(negedge clk);
    if (reset) begin
      full_m = 1'b0;
      foreach (pend_m[i]) pend_m[i] = 1'b0;
    end else begin
      if (acc) begin
        txns++;
        $display("txn %0d: op=%h nop=%0d srcty=%0d dst=%0d size=%0d srcval=%h",
                 txns, in_op, in_nop, in_srcty, in_dst, in_size, in_srcval);
        full_m = 1'b1;
        m_op   = in_op;
        m_nop  = in_nop;
        m_dst  = in_dst;
        m_size = in_size;
        m_mem  = 1'b0;
        m_o1   = '0;
        m_o2   = '0;
        if (!in_nop) begin
          m_o1 = zext_m(reg_now(in_dst), in_size);
          if (in_srcty == 2'd0)      m_o2 = zext_m(reg_now(src), in_size);
          else if (in_srcty == 2'd1) begin m_o2 = in_srcval; m_mem = 1'b1; end
          else                       m_o2 = zext_m(in_srcval, in_size);
        end
      end else if (out_ready) begin
        full_m = 1'b0;
      end
      if (wb_valid) pend_m[wb_reg] = 1'b0;
      if (acc && !in_nop) pend_m[in_dst] = 1'b1;
    end
    if (wb_valid) rf_m[wb_reg] = wb_data;
  endtask

  task automatic drive(input bit nop, input logic [1:0] ty, input logic [63:0] sv,
                       input logic [3:0] dst, input logic [1:0] sz);
    in_valid  = 1'b1;
    in_op     = 8'($urandom);
    in_nop    = nop;
    in_srcty  = ty;
    in_srcval = sv;
    in_dst    = dst;
    in_size   = sz;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_oper1", out_oper1, 0);
    check_val("rst_out_oper2", out_oper2, 0);
    check_val("rst_out_misc", {out_op, out_nop, out_mem, out_dst, out_size}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (rf_m[i]) rf_m[i] = {$urandom, $urandom};
    full_m = 1'b0;
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_nop = 1'b0; in_srcty = '0;
    in_srcval = '0; in_dst = '0; in_size = '0; wb_valid = 1'b0; wb_reg = '0;
    wb_data = '0; out_ready = 1'b1;
    @(negedge clk);
    cycle();
    check_reset_outputs();
    reset = 1'b0;

    // Byte-sized register operands.
    rf_m[1] = 64'h1234; rf_m[2] = 64'hABCD;
    drive(0, 2'd0, 64'd2, 4'd1, 2'd0);
    cycle();
    check_val("basic_accept", last_rdy, 1);
    in_valid = 1'b0;
    check_val("basic_valid", out_valid, 1);
    check_val("basic_oper1", out_oper1, 64'h34);
    check_val("basic_oper2", out_oper2, 64'hCD);

    // 32-bit immediate truncation.
    drive(0, 2'd2, 64'hFFFF_FFFF_8000_0001, 4'd6, 2'd2);
    cycle();
    in_valid = 1'b0;
    check_val("imm32_oper2", out_oper2, 64'h0000_0000_8000_0001);

    // Read-after-write hazard on r3 resolved by writeback.
    drive(0, 2'd2, 64'h55, 4'd3, 2'd3);
    cycle();
    drive(0, 2'd0, 64'd3, 4'd4, 2'd3);
    cycle();
    check_val("raw_stall0", last_rdy, 0);
    cycle();
    check_val("raw_stall1", last_rdy, 0);
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 64'hDEAD_BEEF_0BAD_F00D;
    cycle();
    check_val("raw_wb_cycle", last_rdy, BYP);
    wb_valid = 1'b0;
    if (BYP) begin
      in_valid = 1'b0;
      check_val("raw_byp_oper2", out_oper2, 64'hDEAD_BEEF_0BAD_F00D);
    end else begin
      cycle();
      check_val("raw_after_wb", last_rdy, 1);
      in_valid = 1'b0;
    end
    cycle();

    // Backpressure: held entry must not change while a second instruction waits.
    drive(0, 2'd2, 64'h77, 4'd7, 2'd1);
    cycle();
    out_ready = 1'b0;
    drive(0, 2'd1, 64'hCAFE_0000_1234_5678, 4'd8, 2'd3);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("bp_ready", last_rdy, 0);
    end
    out_ready = 1'b1;
    cycle();
    check_val("bp_release", last_rdy, 1);
    in_valid = 1'b0;
    check_val("bp_dst", out_dst, 8);
    check_val("bp_addr", out_oper2, 64'hCAFE_0000_1234_5678);
    cycle();

    // Same-cycle set and clear of r5: the set must survive.
    drive(0, 2'd2, 64'h5, 4'd5, 2'd0);
    wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 64'h5555;
    cycle();
    check_val("sb_same_accept", last_rdy, 1);
    wb_valid = 1'b0;
    drive(0, 2'd0, 64'd5, 4'd9, 2'd0);
    cycle();
    check_val("sb_set_wins", last_rdy, 0);

    // Reset while FULL with scoreboard bits set.
    out_ready = 1'b0;
    drive(0, 2'd2, 64'h1, 4'd10, 2'd0);
    cycle();
    reset = 1'b1;
    cycle();
    check_val("rst_ready", last_rdy, 0);
    reset = 1'b0;
    check_reset_outputs();
    out_ready = 1'b1;
    drive(0, 2'd0, 64'd5, 4'd10, 2'd1);
    cycle();
    check_val("post_rst_accept", last_rdy, 1);
    in_valid = 1'b0;
    check_val("post_rst_valid", out_valid, 1);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_reg    = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
        if (pend_m[4'(wb_reg + 4'(k))]) begin
          wb_reg = 4'(wb_reg + 4'(k));
          break;
        end
      end
      wb_data = {$urandom, $urandom};
      cycle();
    end
    reset = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning register/operand width in bits.
REQ-002 SHALL have parameter NREGS, default 16, meaning architectural register count; RIDX_W = $clog2(NREGS).
REQ-003 SHALL have parameter OP_W, default 8, meaning opcode width.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  reset; synchronous and active-high.
REQ-006 SHALL have ports in_valid in 1 / in_ready out 1, the decode-side handshake.
REQ-007 SHALL have ports in_op in OP_W, in_nop in 1, in_srcty in 2 (REGISTER=0, MEMORY=1, IMM=2), in_srcval in XLEN, in_dst in RIDX_W, in_size in 2 (0=8b, 1=16b, 2=32b, 3=64b).
REQ-008 SHALL have ports rf_raddr_a out RIDX_W / rf_rdata_a in XLEN and rf_raddr_b out RIDX_W / rf_rdata_b in XLEN, combinational register-file reads.
REQ-009 SHALL have ports wb_valid in 1, wb_reg in RIDX_W, wb_data in XLEN, the writeback retire notification.
REQ-010 SHALL have ports out_valid out 1 / out_ready in 1, out_op OP_W, out_nop 1, out_mem 1, out_oper1 XLEN, out_oper2 XLEN, out_dst RIDX_W, out_size 2.

Function
REQ-011 SHALL drive rf_raddr_a = in_dst and rf_raddr_b = in_srcval[RIDX_W-1:0] combinationally.
REQ-012 SHALL hold a one-entry output register with states EMPTY and FULL: EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL stays FULL on simultaneous drain and accept.
REQ-013 SHALL assert in_ready = (EMPTY or out_ready) and not stall; accept = in_valid and in_ready; latency from accept to out_valid is exactly 1 cycle.
REQ-014 SHALL maintain an NREGS-bit scoreboard: on accept of a non-nop, set bit in_dst; on wb_valid, clear bit wb_reg; if both hit the same register in one cycle, set wins.
REQ-015 SHALL assert stall when in_valid, not in_nop, and the scoreboard bit of in_dst is set, or the scoreboard bit of the source register is set when in_srcty = REGISTER.
REQ-016 SHALL compute out_oper1 = rf_rdata_a, zero-extended from the in_size width.
REQ-017 SHALL compute out_oper2 as follows: for REGISTER, rf_rdata_b zero-extended from the in_size width; for IMM, in_srcval zero-extended from the in_size width; for MEMORY, the full in_srcval as an address with out_mem = 1.
REQ-018 SHALL treat an in_nop instruction as never stalling, never touching the scoreboard, and passing through with out_nop = 1 and out_oper1/out_oper2 = 0.
REQ-019 SHALL hold all outputs stable while out_valid and not out_ready.
REQ-020 SHALL treat in_srcty = 3 as IMM.

Reset
REQ-021 SHALL on reset clear state to EMPTY, the scoreboard to 0, out_valid to 0 and all other output registers to 0, regardless of any in-flight handshake.
REQ-022 SHALL deassert in_ready during the reset cycle and resume normal operation in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL with OPERAND_FETCH_BYPASS_EN defined, treat a register matching wb_reg while wb_valid as not pending, and substitute wb_data for its rf_rdata in the same cycle.
REQ-024 SHALL without OPERAND_FETCH_BYPASS_EN, stall on that register until the cycle after wb_valid, and never read wb_data.

Structure
REQ-025 SHALL place the operand_t enum (REGISTER/MEMORY/IMM), the size encoding and a zext_by_size function in the shared package operand_pkg.
REQ-026 SHALL implement the scoreboard as sub-module of_scoreboard, with ports set_en/set_idx, clr_en/clr_idx and busy vector.

Verification
REQ-027 SHALL cover: reset, then an instruction with in_srcty=REGISTER, in_size=0, dst=1, src=2, R1=0x1234, R2=0xABCD -> one cycle later out_valid=1, out_oper1=0x34, out_oper2=0xCD.
REQ-028 SHALL cover: in_srcty=IMM, in_size=2, in_srcval=0xFFFF_FFFF_8000_0001 -> out_oper2=0x0000_0000_8000_0001.
REQ-029 SHALL cover: issue dst=3, then next instruction src=3 -> in_ready=0 until wb_valid with wb_reg=3; the instruction is accepted in the same cycle as wb_valid with the macro defined and one cycle later without it.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles with a second in_valid -> outputs unchanged, in_ready=0, no data lost after release.
REQ-031 SHALL cover: same-cycle accept of dst=5 and wb_valid with wb_reg=5 -> scoreboard bit 5 remains set.
REQ-032 SHALL cover: reset asserted while FULL with scoreboard bits set -> next cycle out_valid=0, scoreboard=0, and an instruction accepted immediately after reset deasserts.
